// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: funct3 encodings,
// FSM state codes and size/alignment helpers.
package dmem_access_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Encodings outside RV32I are treated as word accesses.
  function automatic size_e size_of(input logic [2:0] f3);
    size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    case (size_of(f3))
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~lo[0];
      default: ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store side replicates data and builds
// strobes, load side extracts the addressed lane and extends it.
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  strb
);

  size_e       sz;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_fill;

  assign sz = size_of(funct3);

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = data_in[7:0];
      2'd1:    byte_sel = data_in[15:8];
      2'd2:    byte_sel = data_in[23:16];
      default: byte_sel = data_in[31:24];
    endcase
    half_sel = addr_lo[1] ? data_in[31:16] : data_in[15:0];
  end

  always_comb begin
    strb      = 4'b0000;
    data_out  = data_in;
    sign_fill = 1'b0;
    if (is_store) begin
      case (sz)
        SZ_B: begin
          strb     = 4'b0001 << addr_lo;
          data_out = {4{data_in[7:0]}};
        end
        SZ_H: begin
          strb     = 4'b0011 << addr_lo;
          data_out = {2{data_in[15:0]}};
        end
        default: begin
          strb     = 4'b1111;
          data_out = data_in;
        end
      endcase
    end else begin
      // funct3[2] marks the zero-extending variants (LBU/LHU)
      case (sz)
        SZ_B: begin
          sign_fill = ~funct3[2] & byte_sel[7];
          data_out  = {{24{sign_fill}}, byte_sel};
        end
        SZ_H: begin
          sign_fill = ~funct3[2] & half_sel[15];
          data_out  = {{16{sign_fill}}, half_sel};
        end
        default: data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: stalls the pipeline while a
// load/store is in flight on a ready/valid-style bus with timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a MEM-stage load/store; misaligned ones flagged
// WAIT    | mem_req held, bus outputs stable, counting toward timeout
// DONE    | one cycle, rdata_MEM valid, pipeline released
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read_MEM,
  input  logic                  mem_write_MEM,
  input  logic [2:0]            funct3_MEM,
  input  logic [ADDR_WIDTH-1:0] addr_MEM,
  input  logic [31:0]           wdata_MEM,
  output logic [31:0]           rdata_MEM,
  output logic                  data_mem_hazard,
  output logic                  misalign_err,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic             is_load_q;

  logic             access_req;
  logic             aligned;
  logic             start;
  logic [31:0]      st_data;
  logic [3:0]       st_strb;
  logic [31:0]      ld_data;
  logic [3:0]       ld_strb_unused;

  assign access_req = mem_read_MEM | mem_write_MEM;
  assign aligned    = addr_aligned(funct3_MEM, addr_MEM[1:0]);
  assign start      = (state == ST_IDLE) && access_req && aligned;

  // Gated by rst_n so the stall drops with reset even if MEM inputs stay high.
  assign data_mem_hazard = rst_n & (start | (state == ST_WAIT));

  dmem_lane_align u_store_align (
    .is_store (mem_write_MEM),
    .funct3   (funct3_MEM),
    .addr_lo  (addr_MEM[1:0]),
    .data_in  (wdata_MEM),
    .data_out (st_data),
    .strb     (st_strb)
  );

  dmem_lane_align u_load_align (
    .is_store (1'b0),
    .funct3   (funct3_q),
    .addr_lo  (addr_lo_q),
    .data_in  (mem_rdata),
    .data_out (ld_data),
    .strb     (ld_strb_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      is_load_q    <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      rdata_MEM    <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access_req) begin
            if (aligned) begin
              mem_req   <= 1'b1;
              mem_we    <= mem_write_MEM;
              mem_addr  <= {addr_MEM[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= mem_write_MEM ? st_data : 32'h0;
              mem_wstrb <= st_strb;
              funct3_q  <= funct3_MEM;
              addr_lo_q <= addr_MEM[1:0];
              is_load_q <= mem_read_MEM;
              wait_cnt  <= '0;
              state     <= ST_WAIT;
            end else begin
              misalign_err <= 1'b1;
              rdata_MEM    <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            rdata_MEM <= is_load_q ? ld_data : 32'h0;
            state     <= ST_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            bus_err   <= 1'b1;
            rdata_MEM <= '0;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          wait_cnt <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed test of dmem_access_ctrl with hand-computed expectations.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read_MEM;
  logic        mem_write_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] addr_MEM;
  logic [31:0] wdata_MEM;
  logic [31:0] rdata_MEM;
  logic        data_mem_hazard;
  logic        misalign_err;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int haz;

  dmem_access_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read_MEM    (mem_read_MEM),
    .mem_write_MEM   (mem_write_MEM),
    .funct3_MEM      (funct3_MEM),
    .addr_MEM        (addr_MEM),
    .wdata_MEM       (wdata_MEM),
    .rdata_MEM       (rdata_MEM),
    .data_mem_hazard (data_mem_hazard),
    .misalign_err    (misalign_err),
    .bus_err         (bus_err),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an access in IDLE; mem_ready is raised in WAIT cycle ready_at.
  // Returns in the DONE cycle with the number of stalled cycles seen.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ready_at, input logic [31:0] rdat,
                        output int haz_cycles);
    mem_read_MEM  = rd;
    mem_write_MEM = wr;
    funct3_MEM    = f3;
    addr_MEM      = a;
    wdata_MEM     = wd;
    #1;
    haz_cycles = int'(data_mem_hazard);
    for (int i = 1; i <= ready_at; i++) begin
      tick();
      if (i == ready_at) begin
        mem_ready = 1'b1;
        mem_rdata = rdat;
      end
      haz_cycles += int'(data_mem_hazard);
    end
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic end_access();
    mem_read_MEM  = 1'b0;
    mem_write_MEM = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read_MEM = 1'b0;
    mem_write_MEM = 1'b0;
    funct3_MEM = 3'b000;
    addr_MEM = 32'h0;
    wdata_MEM = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    #12;
    chk("rst_mem_req",   {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we",    {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_rdata",     rdata_MEM, 32'h0);
    chk("rst_errs",      {30'h0, misalign_err, bus_err}, 32'h0);
    chk("rst_hazard",    {31'h0, data_mem_hazard}, 32'h0);
    rst_n = 1'b1;
    tick();

    // SW 0x104, ready in second WAIT cycle, inputs scrambled during WAIT
    mem_write_MEM = 1'b1;
    funct3_MEM = 3'b010;
    addr_MEM = 32'h104;
    wdata_MEM = 32'hDEADBEEF;
    #1;
    chk("sw_haz_idle", {31'h0, data_mem_hazard}, 32'h1);
    tick();
    chk("sw_req_w1",   {31'h0, mem_req}, 32'h1);
    chk("sw_we_w1",    {31'h0, mem_we}, 32'h1);
    chk("sw_addr",     mem_addr, 32'h104);
    chk("sw_wstrb",    {28'h0, mem_wstrb}, 32'hF);
    chk("sw_wdata",    mem_wdata, 32'hDEADBEEF);
    chk("sw_haz_w1",   {31'h0, data_mem_hazard}, 32'h1);
    wdata_MEM = 32'h0;
    addr_MEM = 32'h999;
    tick();
    chk("sw_wdata_stable", mem_wdata, 32'hDEADBEEF);
    chk("sw_addr_stable",  mem_addr, 32'h104);
    chk("sw_haz_w2",       {31'h0, data_mem_hazard}, 32'h1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("sw_haz_done", {31'h0, data_mem_hazard}, 32'h0);
    chk("sw_req_done", {31'h0, mem_req}, 32'h0);
    end_access();

    // LB 0x203: lane 3 = 0x80, sign-extended
    access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 1, 32'h80FFFF7F, haz);
    chk("lb_rdata",  rdata_MEM, 32'hFFFFFF80);
    chk("lb_hazcnt", 32'(haz), 32'd2);
    chk("lb_addr",   mem_addr, 32'h200);
    chk("lb_wstrb",  {28'h0, mem_wstrb}, 32'h0);
    end_access();
    chk("lb_hold", rdata_MEM, 32'hFFFFFF80);

    access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 1, 32'h80FFFF7F, haz);
    chk("lbu_rdata", rdata_MEM, 32'h00000080);
    end_access();

    // SH 0x2: upper data bits must be ignored
    access(1'b0, 1'b1, 3'b001, 32'h2, 32'h5A5A1234, 1, 32'h0, haz);
    chk("sh_wstrb", {28'h0, mem_wstrb}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    end_access();

    // SB 0x1: byte replicated, strobe lane 1
    access(1'b0, 1'b1, 3'b000, 32'h1, 32'h000000A5, 1, 32'h0, haz);
    chk("sb_wstrb", {28'h0, mem_wstrb}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    end_access();

    access(1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 1, 32'h80010000, haz);
    chk("lh_rdata", rdata_MEM, 32'hFFFF8001);
    end_access();

    access(1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 1, 32'h1234F00D, haz);
    chk("lhu_rdata", rdata_MEM, 32'h0000F00D);
    end_access();

    // LW 0x6 is misaligned; a stray mem_ready in IDLE must do nothing
    mem_read_MEM = 1'b1;
    funct3_MEM = 3'b010;
    addr_MEM = 32'h6;
    mem_ready = 1'b1;
    #1;
    chk("mis_haz", {31'h0, data_mem_hazard}, 32'h0);
    tick();
    mem_ready = 1'b0;
    chk("mis_err",   {31'h0, misalign_err}, 32'h1);
    chk("mis_req",   {31'h0, mem_req}, 32'h0);
    chk("mis_rdata", rdata_MEM, 32'h0);
    chk("mis_haz2",  {31'h0, data_mem_hazard}, 32'h0);
    end_access();

    // Load a nonzero value so the timeout zeroing is visible
    access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1, 32'h11223344, haz);
    chk("lw_rdata", rdata_MEM, 32'h11223344);
    end_access();

    // LW with no mem_ready: timeout after 4 WAIT cycles
    mem_read_MEM = 1'b1;
    funct3_MEM = 3'b010;
    addr_MEM = 32'h10;
    for (int i = 0; i < 4; i++) tick();
    chk("to_req_w4",  {31'h0, mem_req}, 32'h1);
    chk("to_berr_w4", {31'h0, bus_err}, 32'h0);
    tick();
    chk("to_berr",  {31'h0, bus_err}, 32'h1);
    chk("to_req",   {31'h0, mem_req}, 32'h0);
    chk("to_rdata", rdata_MEM, 32'h0);
    chk("to_haz",   {31'h0, data_mem_hazard}, 32'h0);
    chk("mis_sticky", {31'h0, misalign_err}, 32'h1);
    end_access();
    chk("berr_sticky", {31'h0, bus_err}, 32'h1);

    // Reset in the middle of WAIT
    mem_read_MEM = 1'b1;
    funct3_MEM = 3'b010;
    addr_MEM = 32'h20;
    tick();
    chk("rw_req_wait", {31'h0, mem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_req_async", {31'h0, mem_req}, 32'h0);
    chk("rw_haz_async", {31'h0, data_mem_hazard}, 32'h0);
    chk("rw_errs_clr",  {30'h0, misalign_err, bus_err}, 32'h0);
    mem_read_MEM = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    access(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 1, 32'hCAFEF00D, haz);
    chk("rw_after_rdata",  rdata_MEM, 32'hCAFEF00D);
    chk("rw_after_hazcnt", 32'(haz), 32'd2);
    chk("rw_after_addr",   mem_addr, 32'h24);
    end_access();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
